noise_channel: RTL

- Second-generation NES pAPU noise voice. Replaces the bare LFSR/period/length block with a CPU write port, envelope generator, frame-sequencer-driven length counter and status-enable gating.
- Sits between the register decode (writes to $400C–$400F) and the channel mixer. Emits a VOL_W-bit volume sample every clk.
- Parametrised for LFSR length, short-mode tap, timer width and NTSC/PAL period table.

---
 rtl/noise_pkg.sv | 40 ++++
 rtl/apu_envelope.sv | 38 +++
 rtl/noise_channel.sv | 108 ++++++++++
 3 files changed

// File: rtl/noise_pkg.sv
// Shared constants for the noise voice: length/period lookup tables and register map.
package noise_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;  // $400C
    localparam logic [1:0] ADDR_UNUSED = 2'd1;  // $400D
    localparam logic [1:0] ADDR_PERIOD = 2'd2;  // $400E
    localparam logic [1:0] ADDR_LEN    = 2'd3;  // $400F

    localparam logic [7:0] LEN_TABLE [32] = '{
        8'd10,  8'd254, 8'd20,  8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
        8'd160, 8'd8,   8'd60,  8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
        8'd12,  8'd16,  8'd24,  8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
        8'd192, 8'd24,  8'd72,  8'd26, 8'd16, 8'd28, 8'd32, 8'd30
    };

    localparam int unsigned PERIOD_NTSC [16] = '{
        4, 8, 16, 32, 64, 96, 128, 160, 202, 254, 380, 508, 762, 1016, 2034, 4068
    };

    localparam int unsigned PERIOD_PAL [16] = '{
        4, 8, 14, 30, 60, 88, 118, 148, 188, 236, 354, 472, 708, 944, 1890, 3778
    };

    typedef struct packed {
        logic       en;
        logic [1:0] addr;
        logic [7:0] data;
    } wr_req_t;

    function automatic int unsigned max_period(input bit pal);
        int unsigned m;
        m = 0;
        for (int i = 0; i < 16; i++) begin
            if (pal && PERIOD_PAL[i] > m)   m = PERIOD_PAL[i];
            if (!pal && PERIOD_NTSC[i] > m) m = PERIOD_NTSC[i];
        end
        return m;
    endfunction

endpackage

// File: rtl/apu_envelope.sv
// APU envelope generator: start flag, divider and 4-bit decay level with optional loop.
module apu_envelope (
    input  logic       clk,
    input  logic       rst,
    input  logic       qframe,
    input  logic       start_set,
    input  logic       loop,
    input  logic [3:0] n,
    output logic [3:0] decay
);
    logic       start;
    logic [3:0] div;

    always_ff @(posedge clk) begin
        if (rst) begin
            start <= 1'b0;
            div   <= 4'd0;
            decay <= 4'd0;
        end else begin
            if (qframe) begin
                if (start) begin
                    start <= 1'b0;
                    decay <= 4'd15;
                    div   <= n;
                end else if (div == 4'd0) begin
                    div <= n;
                    if (decay != 4'd0) decay <= decay - 4'd1;
                    else if (loop)     decay <= 4'd15;
                end else begin
                    div <= div - 4'd1;
                end
            end
            // A fresh write outranks the clear so it survives to the following qframe
            if (start_set) start <= 1'b1;
        end
    end

endmodule

// File: rtl/noise_channel.sv
// NES pAPU noise voice: register port, period timer, LFSR, length counter and envelope.
module noise_channel
    import noise_pkg::*;
#(
    parameter int LFSR_W    = 15,
    parameter int TAP_LONG  = 1,
    parameter int TAP_SHORT = 6,
    parameter int TIMER_W   = 12,
    parameter int PAL       = 0,
    parameter int VOL_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             apu_tick,
    input  logic             qframe,
    input  logic             hframe,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             chan_en,
    output logic [VOL_W-1:0] vol,
    output logic             len_active
);
    localparam int unsigned MAX_PERIOD = max_period(PAL != 0);

    if (MAX_PERIOD > (32'd1 << TIMER_W)) begin : g_bad_timer_w
        $error("noise_channel: period table does not fit TIMER_W");
    end
    if (LFSR_W < 8 || TAP_SHORT >= LFSR_W || TAP_LONG >= LFSR_W) begin : g_bad_lfsr
        $error("noise_channel: illegal LFSR width or tap");
    end
    if (VOL_W < 4) begin : g_bad_vol
        $error("noise_channel: VOL_W must hold a 4-bit level");
    end

    wr_req_t             req;
    logic [LFSR_W-1:0]   lfsr;
    logic [TIMER_W-1:0]  timer;
    logic [7:0]          len;
    logic                halt, const_vol, mode;
    logic [3:0]          n, pidx, decay;
    logic                len_wr, fb;
    int unsigned         period_cur;

    assign req        = '{en: wr_en, addr: wr_addr, data: wr_data};
    assign len_wr     = req.en && (req.addr == ADDR_LEN);
    assign period_cur = (PAL != 0) ? PERIOD_PAL[pidx] : PERIOD_NTSC[pidx];
    assign fb         = lfsr[0] ^ lfsr[mode ? TAP_SHORT : TAP_LONG];
    assign len_active = (len != 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            halt      <= 1'b0;
            const_vol <= 1'b0;
            n         <= 4'd0;
            mode      <= 1'b0;
            pidx      <= 4'd0;
        end else if (req.en) begin
            if (req.addr == ADDR_CTRL) begin
                halt      <= req.data[5];
                const_vol <= req.data[4];
                n         <= req.data[3:0];
            end
            if (req.addr == ADDR_PERIOD) begin
                mode <= req.data[7];
                pidx <= req.data[3:0];
            end
        end
    end

    // Period changes are picked up only at the next expiry, never mid-count
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
            lfsr  <= LFSR_W'(1);
        end else if (apu_tick) begin
            if (timer == '0) begin
                timer <= TIMER_W'(period_cur - 32'd1);
                lfsr  <= {fb, lfsr[LFSR_W-1:1]};
            end else begin
                timer <= timer - TIMER_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !chan_en)                    len <= 8'd0;
        else if (len_wr)                        len <= LEN_TABLE[req.data[7:3]];
        else if (hframe && !halt && len != 8'd0) len <= len - 8'd1;
    end

    apu_envelope u_env (
        .clk       (clk),
        .rst       (rst),
        .qframe    (qframe),
        .start_set (len_wr),
        .loop      (halt),
        .n         (n),
        .decay     (decay)
    );

    always_ff @(posedge clk) begin
        if (rst)                               vol <= '0;
        else if (len == 8'd0 || lfsr[0])       vol <= '0;
        else                                   vol <= VOL_W'(const_vol ? n : decay);
    end

endmodule
